// File: rtl/wbu_regfile.sv
// Write-back receiver: 2-entry in-order commit queue draining into a 32-entry GPR array (x0 = 0).
// Define REGFILE_BYPASS_EN to forward queued writes to the read ports; otherwise reads flag rd_hazard.
module wbu_regfile #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int DATA_WIDTH     = 32,
   parameter int NR_REGS        = 32,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wb_valid,
   output logic                      wb_ready,
   input  logic                      wb_wen,
   input  logic [REG_ADDR_WIDTH-1:0] wb_waddr,
   input  logic [DATA_WIDTH-1:0]     wb_wdata,
   input  logic                      commit_hold,
   input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
   output logic [DATA_WIDTH-1:0]     rs1_data,
   input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
   output logic [DATA_WIDTH-1:0]     rs2_data,
   output logic                      rd_hazard,
   output logic [CNT_WIDTH-1:0]      commit_cnt,
   output logic                      q_empty
);

   logic [1:0][REG_ADDR_WIDTH-1:0] q_addr;
   logic [1:0][DATA_WIDTH-1:0]     q_data;
   logic                           head, tail;
   logic [1:0]                     count;
   logic [NR_REGS-1:0][DATA_WIDTH-1:0] regs;

   logic push, pop, full;
   logic [1:0] ent_vld;

   assign full     = (count == 2'd2);
   assign wb_ready = !full;
   assign q_empty  = (count == 2'd0);
   assign push     = wb_valid && wb_ready && wb_wen && (wb_waddr != '0);
   assign pop      = !commit_hold && !q_empty;

   always_comb begin
      ent_vld = 2'b00;
      if (full)
         ent_vld = 2'b11;
      else if (count == 2'd1)
         ent_vld[head] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head       <= 1'b0;
         tail       <= 1'b0;
         count      <= 2'd0;
         commit_cnt <= '0;
         q_addr     <= '0;
         q_data     <= '0;
         regs       <= '0;
      end else begin
         if (push) begin
            q_addr[tail] <= wb_waddr;
            q_data[tail] <= wb_wdata;
            tail         <= ~tail;
         end
         if (pop) begin
            // Filtering keeps x0 out of the queue; the guard makes it unconditional.
            if (q_addr[head] != '0)
               regs[q_addr[head]] <= q_data[head];
            head       <= ~head;
            commit_cnt <= commit_cnt + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   logic [1:0][REG_ADDR_WIDTH-1:0] rd_addr;
   logic [1:0][DATA_WIDTH-1:0]     rd_data;
   logic [1:0]                     rd_match;

   assign rd_addr[0] = rs1_addr;
   assign rd_addr[1] = rs2_addr;
   assign rs1_data   = rd_data[0];
   assign rs2_data   = rd_data[1];

   genvar p;
   generate
      for (p = 0; p < 2; p++) begin : g_rd
         logic young_hit, old_hit;
         // When two entries are queued, the youngest sits just behind tail and the older at head.
         assign young_hit = ent_vld[~tail] && (q_addr[~tail] == rd_addr[p]);
         assign old_hit   = ent_vld[head]  && (q_addr[head]  == rd_addr[p]);
         assign rd_match[p] = (rd_addr[p] != '0) && (young_hit || old_hit);

         always_comb begin
            rd_data[p] = regs[rd_addr[p]];
            if (rd_addr[p] == '0)
               rd_data[p] = '0;
`ifdef REGFILE_BYPASS_EN
            else if (young_hit)
               rd_data[p] = q_data[~tail];
            else if (old_hit)
               rd_data[p] = q_data[head];
`endif
         end
      end
   endgenerate

`ifdef REGFILE_BYPASS_EN
   assign rd_hazard = 1'b0;
   logic unused_match;
   assign unused_match = ^rd_match;
`else
   assign rd_hazard = |rd_match;
`endif

endmodule

// File: tb/tb_wbu_regfile.sv
// Directed self-checking bench for wbu_regfile; expectations follow the REGFILE_BYPASS_EN setting.
module tb_wbu_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid, wb_wen, commit_hold;
   logic        wb_ready, rd_hazard, q_empty;
   logic [4:0]  wb_waddr, rs1_addr, rs2_addr;
   logic [31:0] wb_wdata, rs1_data, rs2_data, commit_cnt;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   always #5 clk = ~clk;

   wbu_regfile dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wen(wb_wen),
      .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .commit_hold(commit_hold),
      .rs1_addr(rs1_addr), .rs1_data(rs1_data),
      .rs2_addr(rs2_addr), .rs2_data(rs2_data),
      .rd_hazard(rd_hazard), .commit_cnt(commit_cnt), .q_empty(q_empty)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic en);
      wb_valid = 1'b1; wb_wen = en; wb_waddr = a; wb_wdata = d;
   endtask

   task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
      rs1_addr = a1; rs2_addr = a2;
      #1;
   endtask

   initial begin
      rst = 1'b1; wb_valid = 1'b0; wb_wen = 1'b0; wb_waddr = '0; wb_wdata = '0;
      commit_hold = 1'b0; rs1_addr = '0; rs2_addr = '0;
      step(); step();
      rst = 1'b0;
      #1;
      chk("rst_q_empty", {31'd0, q_empty}, 32'd1);
      chk("rst_ready", {31'd0, wb_ready}, 32'd1);
      chk("rst_cnt", commit_cnt, 32'd0);
      chk("rst_hazard", {31'd0, rd_hazard}, 32'd0);
      for (int i = 0; i < 32; i++) begin
         rd(i[4:0], 5'(31 - i));
         chk("rst_rs1", rs1_data, 32'd0);
         chk("rst_rs2", rs2_data, 32'd0);
      end

      // single write to x5
      wr(5'd5, 32'hDEADBEEF, 1'b1);
      #1 chk("w1_ready", {31'd0, wb_ready}, 32'd1);
      step();
      wb_valid = 1'b0;
      rd(5'd5, 5'd0);
      chk("w1_fwd", rs1_data, BYP ? 32'hDEADBEEF : 32'd0);
      chk("w1_haz", {31'd0, rd_hazard}, BYP ? 32'd0 : 32'd1);
      chk("w1_q_busy", {31'd0, q_empty}, 32'd0);
      chk("w1_cnt0", commit_cnt, 32'd0);
      step();
      chk("w1_cnt1", commit_cnt, 32'd1);
      chk("w1_q_empty", {31'd0, q_empty}, 32'd1);
      chk("w1_arr", rs1_data, 32'hDEADBEEF);
      chk("w1_haz_clr", {31'd0, rd_hazard}, 32'd0);

      // filtered writes: waddr=0, then wen=0
      wr(5'd0, 32'h1234, 1'b1);
      step();
      chk("f0_q_empty", {31'd0, q_empty}, 32'd1);
      wr(5'd3, 32'h5555, 1'b0);
      step();
      chk("f3_q_empty", {31'd0, q_empty}, 32'd1);
      wb_valid = 1'b0;
      rd(5'd0, 5'd3);
      chk("f_x0", rs1_data, 32'd0);
      chk("f_x3", rs2_data, 32'd0);
      step();
      chk("f_cnt", commit_cnt, 32'd1);

      // hold: fill queue, third write blocked
      commit_hold = 1'b1;
      wr(5'd1, 32'h11, 1'b1);
      step();
      wr(5'd1, 32'h22, 1'b1);
      step();
      wr(5'd2, 32'h33, 1'b1);
      #1 chk("h_ready_full", {31'd0, wb_ready}, 32'd0);
      step();
      rd(5'd1, 5'd2);
      chk("h_youngest", rs1_data, BYP ? 32'h22 : 32'd0);
      chk("h_x2_notq", rs2_data, 32'd0);
      chk("h_haz", {31'd0, rd_hazard}, BYP ? 32'd0 : 32'd1);
      chk("h_cnt", commit_cnt, 32'd1);
      commit_hold = 1'b0;
      step();
      chk("h_d1_cnt", commit_cnt, 32'd2);
      chk("h_d1_ready", {31'd0, wb_ready}, 32'd1);
      chk("h_d1_x1", rs1_data, BYP ? 32'h22 : 32'h11);
      step();
      wb_valid = 1'b0;
      chk("h_d2_cnt", commit_cnt, 32'd3);
      chk("h_d2_q", {31'd0, q_empty}, 32'd0);
      step();
      rd(5'd1, 5'd2);
      chk("h_d3_cnt", commit_cnt, 32'd4);
      chk("h_d3_q", {31'd0, q_empty}, 32'd1);
      chk("h_x1_final", rs1_data, 32'h22);
      chk("h_x2_final", rs2_data, 32'h33);

      // reset with two pending entries
      commit_hold = 1'b1;
      wr(5'd9, 32'h99, 1'b1);
      step();
      wr(5'd10, 32'hAA, 1'b1);
      step();
      wb_valid = 1'b0;
      chk("r_pend", {31'd0, q_empty}, 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      rd(5'd9, 5'd10);
      chk("r_q_empty", {31'd0, q_empty}, 32'd1);
      chk("r_cnt", commit_cnt, 32'd0);
      chk("r_x9", rs1_data, 32'd0);
      chk("r_x10", rs2_data, 32'd0);
      rd(5'd1, 5'd5);
      chk("r_x1", rs1_data, 32'd0);
      chk("r_x5", rs2_data, 32'd0);
      commit_hold = 1'b0;
      step();
      chk("r_cnt_after", commit_cnt, 32'd0);
      chk("r_x1_after", rs1_data, 32'd0);

      // hazard / stale read on x7
      wr(5'd7, 32'h70, 1'b1);
      step();
      wb_valid = 1'b0;
      step();
      commit_hold = 1'b1;
      wr(5'd7, 32'h77, 1'b1);
      step();
      wb_valid = 1'b0;
      rd(5'd0, 5'd7);
      chk("z_haz", {31'd0, rd_hazard}, BYP ? 32'd0 : 32'd1);
      chk("z_rs2", rs2_data, BYP ? 32'h77 : 32'h70);
      rd(5'd0, 5'd6);
      chk("z_haz_miss", {31'd0, rd_hazard}, 32'd0);
      rd(5'd0, 5'd7);
      commit_hold = 1'b0;
      step();
      chk("z_haz_clr", {31'd0, rd_hazard}, 32'd0);
      chk("z_rs2_final", rs2_data, 32'h77);
      chk("z_cnt", commit_cnt, 32'd2);
      chk("z_x0", rs1_data, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
